fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
//
// PURPOSE
//   Parametrised single-clock FIFO: successor to the fixed 8x8 FIFO block.
//   Adds a generic width and depth (depth need not be a power of two), an occupancy
//   count, programmable almost-full/almost-empty flags and overflow/underflow error pulses.
//   Sits between a producer and consumer in the same clock domain.
//   Its flags and outputs are checked by the FIFO assertion bind.
//
// PARAMETERS
//   DATA_WIDTH  8  width of data_in/data_out (>=1)
//   DEPTH       8  number of entries (>=2, any integer)
//   AF_LEVEL    6  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    1  almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//   CW          $clog2(DEPTH+1)  count width (localparam, not overridable)
//
// PORTS
//   clk           in   1           single clock, rising edge
//   rst_n         in   1           asynchronous active-low reset
//   wr_en         in   1           write request
//   data_in       in   DATA_WIDTH  write data, sampled with an accepted write
//   rd_en         in   1           read request
//   data_out      out  DATA_WIDTH  read data
//   full          out  1           count == DEPTH
//   empty         out  1           count == 0
//   almost_full   out  1           count >= AF_LEVEL
//   almost_empty  out  1           count <= AE_LEVEL
//   count         out  CW          current occupancy, 0..DEPTH
//   overflow      out  1           1-cycle pulse: a write was rejected
//   underflow     out  1           1-cycle pulse: a read was rejected
//
// BEHAVIOUR
//   - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//     almost_empty=1, almost_full=0, data_out=0, overflow=underflow=0.
//     Storage array is not reset.
//   - Accept rules, using the flags as registered at the edge:
//     write accepted iff wr_en && !full; read accepted iff rd_en && !empty.
//   - Full with wr_en && rd_en: read accepted, write rejected, overflow pulses. Count becomes DEPTH-1.
//   - Empty with wr_en && rd_en: write accepted, read rejected, underflow pulses.
//     data_out holds its value. Count becomes 1.
//   - Both accepted: count unchanged; both pointers advance.
//   - Pointers wrap DEPTH-1 -> 0 by explicit compare; no reliance on power-of-two rollover.
//   - count: +1 on write only, -1 on read only; it never leaves 0..DEPTH.
//   - All flags are decoded from the count register, so they change on the same edge as count.
//   - Standard mode: data_out is registered and updates one cycle after an accepted read.
//     Latency is 1. data_out holds its value when no read is accepted.
//   - overflow/underflow are registered and high for exactly the cycle after the rejected request.
//     They are not sticky.
//   - Data order is strict FIFO; no data is corrupted on any rejected request.
//
// CONFIGURATION
//   FIFO_SYNC_FWFT_EN defined: first-word-fall-through mode.
//     - data_out continuously presents the head entry mem[rd_ptr] whenever !empty.
//     - An accepted rd_en pops the entry; data_out shows the next entry after the edge.
//     - data_out is don't-care while empty and reads as 0 after reset.
//     - A write into an empty FIFO is visible on data_out one cycle after the write edge.
//   Not defined: the standard registered-read behaviour described above.
//
// TESTING (DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1 unless stated)
//   1. Assert rst_n=0 -> immediately empty=1, full=0, count=0, almost_empty=1, data_out=0x00.
//   2. Write 0x01..0x08 on consecutive cycles -> count steps 1..8;
//      almost_empty drops at count 2; almost_full rises at count 6; full rises at count 8.
//      A 9th write of 0xFF -> overflow pulses for 1 cycle and count stays 8.
//      Then 8 reads -> data_out 0x01..0x08 in order, each 1 cycle after its read.
//   3. Hold wr_en=rd_en=1 for 10 cycles at count 3 -> count stays 3 and output order is preserved.
//      At full with both asserted -> count becomes 7 and overflow pulses.
//   4. rd_en on empty -> underflow pulses for 1 cycle, data_out is unchanged and count stays 0.
//      wr_en+rd_en on empty -> count becomes 1 and underflow pulses.
//   5. DEPTH=5: 23 interleaved write/read pairs with data 0x10+i -> pointers wrap several times,
//      every word is returned in order, and count never exceeds 5.
//   6. Drop rst_n mid-burst at count 5 -> all outputs return to reset values asynchronously.
//      The next write/read of 0xA5 returns 0xA5.
//      With FIFO_SYNC_FWFT_EN: a write of 0x3C into empty -> data_out=0x3C on the next cycle with no rd_en.

Source files
------------

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
//
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty flags and one-cycle overflow / underflow pulses.
// DEPTH can be any integer >= 2; pointers wrap by explicit compare.
//
// Build option:
//   FIFO_SYNC_FWFT_EN  defined     -> first-word-fall-through: data_out shows
//                                     the head entry whenever the FIFO is not
//                                     empty (reads as 0 while empty).
//                      not defined -> data_out is registered and updates one
//                                     cycle after an accepted read.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   wr_en         in   write request
//   data_in       in   write data (DATA_WIDTH)
//   rd_en         in   read request
//   data_out      out  read data (DATA_WIDTH)
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  occupancy 0..DEPTH (CW bits)
//   overflow      out  pulse: a write was rejected on the previous edge
//   underflow     out  pulse: a read was rejected on the previous edge
// ---------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 8,
    parameter int  AF_LEVEL   = 6,
    parameter int  AE_LEVEL   = 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, unf_q;
    logic                  wr_acc, rd_acc;

    // Handshake: a request is a single-cycle level sampled at the rising edge.
    // wr_en is accepted iff !full and rd_en iff !empty, both judged from the
    // flags as registered before that edge; a rejected request has no effect
    // on storage, pointers or count and only raises overflow/underflow for
    // the following cycle.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Flags are pure decodes of the count register.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Explicit wrap so non-power-of-two depths work.
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= wr_en && !wr_acc;
            unf_q    <= rd_en && !rd_acc;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head entry falls through; forced to 0 while empty so reset reads 0.
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr8, rd8, wr5, rd5;
  logic [7:0] din;
  logic [7:0] dout8, dout5;
  logic       full8, empty8, af8, ae8, ovf8, unf8;
  logic       full5, empty5, af5, ae5, ovf5, unf5;
  logic [3:0] count8;
  logic [2:0] count5;

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr8), .data_in(din), .rd_en(rd8),
    .data_out(dout8), .full(full8), .empty(empty8), .almost_full(af8),
    .almost_empty(ae8), .count(count8), .overflow(ovf8), .underflow(unf8)
  );

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr5), .data_in(din), .rd_en(rd5),
    .data_out(dout5), .full(full5), .empty(empty5), .almost_full(af5),
    .almost_empty(ae5), .count(count5), .overflow(ovf5), .underflow(unf5)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int         target;
    bit         sel;
    int         cnt;
    bit         ovf;
    bit         unf;
    bit         has_rd;
    bit         chk_dout;
    logic [7:0] dout;
  } st_t;

  st_t        st_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] q8[$];
  logic [7:0] q5[$];
  logic [7:0] last8 = 8'h00;
  logic [7:0] last5 = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model step: issue one cycle of stimulus to one FIFO and
  // record what must be visible after the edge.
  task automatic drive(input bit sel, input bit wr, input bit rd, input logic [7:0] d);
    int         depth;
    int         cnt_old;
    bit         wacc;
    bit         racc;
    logic [7:0] v;
    st_t        e;
    depth   = sel ? 5 : 8;
    cnt_old = sel ? q5.size() : q8.size();
    wacc    = wr && (cnt_old != depth);
    racc    = rd && (cnt_old != 0);
    e.has_rd   = 1'b0;
    e.chk_dout = 1'b1;
    if (racc) begin
      if (sel) begin v = q5.pop_front(); last5 = v; end
      else     begin v = q8.pop_front(); last8 = v; end
`ifndef FIFO_SYNC_FWFT_EN
      exp_q.push_back(v);
      e.has_rd = 1'b1;
`endif
    end
    if (wacc) begin
      if (sel) q5.push_back(d);
      else     q8.push_back(d);
    end
    e.target = cyc + 1;
    e.sel    = sel;
    e.cnt    = sel ? q5.size() : q8.size();
    e.ovf    = wr && !wacc;
    e.unf    = rd && !racc;
`ifdef FIFO_SYNC_FWFT_EN
    e.chk_dout = (e.cnt > 0);
    e.dout     = (e.cnt > 0) ? (sel ? q5[0] : q8[0]) : 8'h00;
`else
    e.dout     = sel ? last5 : last8;
`endif
    st_q.push_back(e);
    wr8 = !sel && wr;
    rd8 = !sel && rd;
    wr5 = sel && wr;
    rd5 = sel && rd;
    din = d;
    @(posedge clk);
    #1;
    wr8 = 1'b0; rd8 = 1'b0; wr5 = 1'b0; rd5 = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst_count8", count8, 0);  chk("rst_count5", count5, 0);
    chk("rst_empty8", empty8, 1);  chk("rst_empty5", empty5, 1);
    chk("rst_full8", full8, 0);    chk("rst_full5", full5, 0);
    chk("rst_ae8", ae8, 1);        chk("rst_ae5", ae5, 1);
    chk("rst_af8", af8, 0);        chk("rst_af5", af5, 0);
    chk("rst_dout8", dout8, 0);    chk("rst_dout5", dout5, 0);
    chk("rst_ovf8", ovf8, 0);      chk("rst_unf8", unf8, 0);
    chk("rst_ovf5", ovf5, 0);      chk("rst_unf5", unf5, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    st_q.delete();
    exp_q.delete();
    q8.delete();
    q5.delete();
    last8 = 8'h00;
    last5 = 8'h00;
    #1;
    reset_checks();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whose edge has passed and compares.
  st_t m_e;
  int  m_depth, m_af;
  always @(negedge clk) begin
    if (rst_n) begin
      while (st_q.size() > 0 && st_q[0].target <= cyc) begin
        m_e     = st_q.pop_front();
        m_depth = m_e.sel ? 5 : 8;
        m_af    = m_e.sel ? 4 : 6;
        chk("count",        m_e.sel ? int'(count5) : int'(count8), m_e.cnt);
        chk("full",         m_e.sel ? full5 : full8,   int'(m_e.cnt == m_depth));
        chk("empty",        m_e.sel ? empty5 : empty8, int'(m_e.cnt == 0));
        chk("almost_full",  m_e.sel ? af5 : af8,       int'(m_e.cnt >= m_af));
        chk("almost_empty", m_e.sel ? ae5 : ae8,       int'(m_e.cnt <= 1));
        chk("overflow",     m_e.sel ? ovf5 : ovf8,     int'(m_e.ovf));
        chk("underflow",    m_e.sel ? unf5 : unf8,     int'(m_e.unf));
        if (m_e.has_rd) begin
          if (exp_q.size() == 0) begin
            chk("rd_data_queue", 0, 1);
          end else begin
            chk("rd_data", m_e.sel ? dout5 : dout8, exp_q.pop_front());
          end
        end else if (m_e.chk_dout) begin
          chk("dout_hold", m_e.sel ? dout5 : dout8, m_e.dout);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    wr8 = 1'b0; rd8 = 1'b0; wr5 = 1'b0; rd5 = 1'b0; din = 8'h00;
    #2;
    apply_reset();

    // Fill 1..8, overflow attempt, drain in order.
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, 1'b0, 8'(i));
    drive(1'b0, 1'b1, 1'b0, 8'hFF);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Simultaneous read/write at count 3, then at full.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
    drive(1'b0, 1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);

    // Empty-side corner cases.
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h77);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // DEPTH=5: interleaved pairs wrap the pointers, then fill past full.
    for (int i = 0; i < 23; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
      drive(1'b1, 1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
    drive(1'b1, 1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b1, 8'h00);

    // Random traffic on both depths with varying write bias.
    for (int i = 0; i < 300; i++)
      drive(1'b1, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom));
    for (int i = 0; i < 300; i++)
      drive(1'b0, $urandom_range(0, 99) < ((i / 100 == 1) ? 30 : 65),
            $urandom_range(0, 99) < 50, 8'($urandom));

    // Mid-burst reset at count 5.
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    @(negedge clk);
    #1;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 8'hA5);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Write into empty, then idle cycles with no read.
    drive(1'b0, 1'b1, 1'b0, 8'h3C);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", st_q.size() + exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
